fft_r2_pair_sequencer: RTL
==========================

Name: fft_r2_pair_sequencer

Overview:
- Sits directly downstream of the radix-2 FFT index generator.
- Consumes its alternating A/B index stream: A on one valid beat, partner B on the next.
- For each butterfly it issues:
  - dual-port working-RAM read addresses;
  - a twiddle ROM address;
  - the matching write-back addresses, delayed by the butterfly datapath latency.
- Checks pair legality and reports completion once the last write-back has left the pipeline.

Parameters:
bw_fftp, 4, index width; FFT size = 2^bw_fftp
bw_stage, 2, stage number width (must hold bw_fftp-1)
LATENCY, 4, cycles from RdEn to WrEn (butterfly datapath depth), >=1

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous active-high reset
Start  in  1  one-cycle pulse; begin new transform
In_Valid  in  1  In_Index/In_Stage valid this cycle
In_Index  in  bw_fftp  butterfly index (A then B)
In_Stage  in  bw_stage  stage of current index
In_End  in  1  one-cycle pulse; upstream finished all stages
RdEn  out  1  read strobe, one cycle per pair
RdAddrA  out  bw_fftp  read address port A
RdAddrB  out  bw_fftp  read address port B
TwAddr  out  bw_fftp-1  twiddle ROM address
WrEn  out  1  write-back strobe
WrAddrA  out  bw_fftp  write address port A
WrAddrB  out  bw_fftp  write address port B
PairCount  out  bw_fftp+bw_stage  pairs issued since Start
PairErr  out  1  sticky illegal-pair flag
Busy  out  1  transform in progress
Done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM IDLE; phase=A; delay line empty.
- FSM states:
  - IDLE -> RUN on Start.
  - RUN -> DRAIN on In_End.
  - DRAIN -> IDLE when delay line empty. Done=1 for exactly that one cycle.
  - Busy=1 in RUN and DRAIN.
- Start in any state:
  - clears phase, PairCount, PairErr;
  - flushes delay line (no WrEn for in-flight pairs);
  - enters RUN.
  - Inputs on the Start cycle are accepted.
- Inputs accepted only in RUN (or on the Start cycle).
- Input pairing:
  - phase=A and In_Valid: latch In_Index as A and In_Stage as S; phase->B.
  - phase=B and In_Valid: latch B; phase->A; pair complete.
  - In_Valid low holds phase; gaps between A and B are legal.
- Issue, cycle after pair complete:
  - RdEn=1, RdAddrA=A, RdAddrB=B.
  - TwAddr = (A mod span) << S, truncated to bw_fftp-1 bits, where span = 2^(bw_fftp-1-S).
  - PairCount increments in the same cycle; it wraps at 2^(bw_fftp+bw_stage).
  - RdAddr/TwAddr hold their last value when RdEn=0.
- Legality checks (PairErr set, stays set until Start or Reset):
  - B != A | span;
  - A has bit (bw_fftp-1-S) set;
  - In_Stage differs between A and B beats;
  - S >= bw_fftp.
- An illegal pair is still issued unchanged.
- Write-back:
  - WrEn, WrAddrA, WrAddrB equal RdEn, RdAddrA, RdAddrB delayed exactly LATENCY cycles.
  - Back-to-back pairs are supported at one pair per 2 cycles; the delay line must also accept one per cycle.
- Drain:
  - In_End while phase=B (dangling A): discard the A and set PairErr.
  - In_End while a completed pair awaits issue: issue it, then drain.
  - Done asserts the cycle after the final WrEn, or the cycle after In_End if nothing is in flight.
- Reset mid-operation returns to reset state immediately; no WrEn afterward.

Test Plan:
- bw_fftp=4, LATENCY=4. Start, then A=0,B=8 (S=0) -> RdEn one cycle after B with RdAddrA=0, RdAddrB=8, TwAddr=0; WrEn 4 cycles later with WrAddrA=0, WrAddrB=8; PairCount=1.
- Stage 1 pair A=3,B=7 -> TwAddr=6. Stage 3 pair A=6,B=7 -> TwAddr=0. Stage 2 pair A=9,B=11 -> TwAddr=4. PairErr remains 0 throughout.
- Full transform: 4 stages x 8 pairs, A/B on consecutive cycles, then In_End -> PairCount=32, 32 WrEn pulses, Done single pulse one cycle after last WrEn, Busy falls with Done.
- Illegal pair A=2,B=3 at S=0 -> PairErr=1, pair still issued. A later Start clears PairErr to 0.
- In_Valid gap: A=1, three idle cycles, B=9 -> single RdEn for (1,9). Then In_End after a lone A=5 -> no RdEn for 5, PairErr=1, Done asserted.
- Start issued with 2 pairs in flight -> no WrEn for them, PairCount=0. Reset asserted mid-RUN -> all outputs 0 on the next edge, Done never pulses.

Source files
------------

// File: rtl/fft_r2_pair_sequencer_if.sv
// fft_r2_pair_sequencer_if: index-stream inputs and RAM/twiddle address outputs of the pair sequencer.
interface fft_r2_pair_sequencer_if #(
  parameter int bw_fftp = 4,
  parameter int bw_stage = 2
);
  logic Start, In_Valid, In_End;
  logic [bw_fftp-1:0] In_Index;
  logic [bw_stage-1:0] In_Stage;
  logic RdEn, WrEn, PairErr, Busy, Done;
  logic [bw_fftp-1:0] RdAddrA, RdAddrB, WrAddrA, WrAddrB;
  logic [bw_fftp-2:0] TwAddr;
  logic [bw_fftp+bw_stage-1:0] PairCount;
  modport master (
    output Start, In_Valid, In_Index, In_Stage, In_End,
    input RdEn, RdAddrA, RdAddrB, TwAddr, WrEn, WrAddrA, WrAddrB, PairCount, PairErr, Busy, Done
  );
  modport slave (
    input Start, In_Valid, In_Index, In_Stage, In_End,
    output RdEn, RdAddrA, RdAddrB, TwAddr, WrEn, WrAddrA, WrAddrB, PairCount, PairErr, Busy, Done
  );
endinterface

// File: rtl/fft_r2_pair_sequencer.sv
// fft_r2_pair_sequencer: pairs the A/B index stream into read/twiddle addresses and
// LATENCY-delayed write-back addresses, flags illegal pairs and pulses Done after the last write.
module fft_r2_pair_sequencer #(
  parameter int bw_fftp = 4,
  parameter int bw_stage = 2,
  parameter int LATENCY = 4
) (
  input logic Clock,
  input logic Reset,
  fft_r2_pair_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, stateNext;
  logic phaseB, accept, phaseCur, pairDone, dangling, illegal, empty;
  logic [bw_fftp-1:0] regA, span;
  logic [bw_fftp-2:0] mask;
  logic [bw_stage-1:0] regS;
  logic [LATENCY:0] enChain;
  logic [LATENCY-1:0] pipeEn;
  logic [bw_fftp-1:0] pipeA [LATENCY];
  logic [bw_fftp-1:0] pipeB [LATENCY];
  assign accept = bus.Start || state == RUN;
  assign phaseCur = phaseB && !bus.Start;
  assign pairDone = accept && bus.In_Valid && phaseCur;
  // a beat that leaves phase=B when In_End arrives strands an A without its partner
  assign dangling = accept && bus.In_End && (phaseCur != bus.In_Valid);
  assign span = {1'b1, {(bw_fftp-1){1'b0}}} >> regS;
  assign mask = {(bw_fftp-1){1'b1}} >> regS;
  assign illegal = span == '0 || |(regA & span) || bus.In_Index != (regA | span) || bus.In_Stage != regS;
  assign enChain = {pipeEn, bus.RdEn};
  assign empty = enChain == '0;
  assign bus.WrEn = pipeEn[LATENCY-1];
  assign bus.WrAddrA = pipeA[LATENCY-1];
  assign bus.WrAddrB = pipeB[LATENCY-1];
  assign bus.Busy = state != IDLE;
  always_comb begin
    bus.Done = state == DRAIN && empty && !bus.Start;
    stateNext = accept ? (bus.In_End ? DRAIN : RUN) : bus.Done ? IDLE : state;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phaseB <= 1'b0;
      regA <= '0;
      regS <= '0;
      bus.RdEn <= 1'b0;
      bus.RdAddrA <= '0;
      bus.RdAddrB <= '0;
      bus.TwAddr <= '0;
      bus.PairCount <= '0;
      bus.PairErr <= 1'b0;
      pipeEn <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipeA[i] <= '0;
        pipeB[i] <= '0;
      end
    end else begin
      if (accept) phaseB <= (phaseCur != bus.In_Valid) && !bus.In_End;
      if (accept && bus.In_Valid && !phaseCur) begin
        regA <= bus.In_Index;
        regS <= bus.In_Stage;
      end
      bus.RdEn <= pairDone;
      if (pairDone) begin
        bus.RdAddrA <= regA;
        bus.RdAddrB <= bus.In_Index;
        bus.TwAddr <= (regA[bw_fftp-2:0] & mask) << regS;
      end
      bus.PairCount <= bus.Start ? '0 : bus.PairCount + (bw_fftp+bw_stage)'(pairDone);
      bus.PairErr <= (bus.PairErr && !bus.Start) || (pairDone && illegal) || dangling;
      // Start drops every in-flight write-back, including a read issued this very cycle
      pipeEn <= bus.Start ? '0 : enChain[LATENCY-1:0];
      pipeA[0] <= bus.RdAddrA;
      pipeB[0] <= bus.RdAddrB;
      for (int i = 1; i < LATENCY; i++) begin
        pipeA[i] <= pipeA[i-1];
        pipeB[i] <= pipeB[i-1];
      end
    end
  end
endmodule
